// File: rtl/ahb_slave_arbiter.sv
// Round-robin arbiter for one AHB slave port, tracking fixed/INCR bursts and locked sequences.
// Latency: hgrant/hmaster/hmastlock are registered one HCLK after the deciding edge; data_sel trails hgrant by one accepted beat.
// Backpressure: hready=0 freezes every register, so no rearbitration or data-phase advance happens during a wait state.
module ahb_slave_arbiter #(
  parameter int MASTER_NUM = 2,
  localparam int IDX_W = (MASTER_NUM > 2) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [MASTER_NUM-1:0]      hreq,
  input  logic [MASTER_NUM-1:0]      hlock,
  input  logic [MASTER_NUM-1:0][1:0] htrans_in,
  input  logic [MASTER_NUM-1:0][2:0] hburst_in,
  input  logic                       hready,
  output logic [MASTER_NUM-1:0]      hgrant,
  output logic [MASTER_NUM-1:0]      data_sel,
  output logic [IDX_W-1:0]           hmaster,
  output logic                       hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;

  localparam logic [MASTER_NUM-1:0] GRANT_LSB = {{(MASTER_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_BURST, ST_LOCK} state_t;

  // What the next accepted edge should do; keeps the register block a plain dispatcher.
  typedef enum logic [2:0] {
    ACT_HOLD, ACT_REARB, ACT_LOCK, ACT_FIXED, ACT_INCR, ACT_DEC, ACT_UNLOCK
  } act_t;

  state_t           state;
  logic [3:0]       beat_cnt;
  logic             undef_len;
  logic [IDX_W-1:0] last_owner;

  logic [1:0]       g_trans;
  logic [2:0]       g_burst;
  logic             g_lock;
  logic [3:0]       fixed_len;
  act_t             nonseq_act;
  act_t             act;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand;

  // Current owner's transfer controls and the burst length it is announcing.
  always_comb begin
    g_trans = htrans_in[hmaster];
    g_burst = hburst_in[hmaster];
    g_lock  = hlock[hmaster];
    case (g_burst[2:1])
      2'b01:   fixed_len = 4'd3;
      2'b10:   fixed_len = 4'd7;
      2'b11:   fixed_len = 4'd15;
      default: fixed_len = 4'd0;
    endcase
  end

  // Round-robin search starting just after the last owner, so the last owner is tried last.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      cand = IDX_W'((int'(last_owner) + k) % MASTER_NUM);
      if (!arb_found && hreq[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Decide the action for the next accepted edge from state and the owner's HTRANS/HBURST/HLOCK.
  always_comb begin
    if (g_lock)
      nonseq_act = ACT_LOCK;
    else if (g_burst == BU_SINGLE)
      nonseq_act = ACT_REARB;
    else if (g_burst == BU_INCR)
      nonseq_act = ACT_INCR;
    else
      nonseq_act = ACT_FIXED;

    act = ACT_HOLD;
    case (state)
      ST_IDLE:  act = ACT_REARB;
      ST_OWNED: act = (g_trans == TR_NONSEQ) ? nonseq_act : ACT_REARB;
      ST_BURST: begin
        case (g_trans)
          TR_SEQ: begin
            if (undef_len)
              act = ACT_HOLD;
            else if (beat_cnt <= 4'd1)
              act = ACT_REARB;   // last beat of the fixed burst; counter never goes below 0
            else
              act = ACT_DEC;
          end
          TR_BUSY:   act = ACT_HOLD;
          TR_IDLE:   act = ACT_REARB;
          TR_NONSEQ: act = nonseq_act;
          default:   act = ACT_HOLD;
        endcase
      end
      ST_LOCK:  act = g_lock ? ACT_HOLD : ACT_UNLOCK;
      default:  act = ACT_REARB;
    endcase
  end

  // Arbiter FSM with registered grant, data-phase select, master index and lock flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      hgrant     <= '0;
      data_sel   <= '0;
      hmaster    <= '0;
      hmastlock  <= 1'b0;
      beat_cnt   <= 4'd0;
      undef_len  <= 1'b0;
      last_owner <= IDX_W'(MASTER_NUM - 1);
    end else if (hready) begin
      data_sel <= hgrant;
      case (act)
        ACT_REARB: begin
          hmastlock <= 1'b0;
          undef_len <= 1'b0;
          beat_cnt  <= 4'd0;
          if (arb_found) begin
            state      <= ST_OWNED;
            hgrant     <= GRANT_LSB << arb_idx;
            hmaster    <= arb_idx;
            last_owner <= arb_idx;
          end else begin
            state   <= ST_IDLE;
            hgrant  <= '0;
            hmaster <= '0;
          end
        end
        ACT_LOCK: begin
          state     <= ST_LOCK;
          hmastlock <= 1'b1;
        end
        ACT_FIXED: begin
          state     <= ST_BURST;
          beat_cnt  <= fixed_len;
          undef_len <= 1'b0;
        end
        ACT_INCR: begin
          state     <= ST_BURST;
          beat_cnt  <= 4'd0;
          undef_len <= 1'b1;
        end
        ACT_DEC:    beat_cnt <= beat_cnt - 4'd1;
        ACT_UNLOCK: begin
          state     <= ST_OWNED;
          hmastlock <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter (MASTER_NUM=2): reset, a vector table of grant sequences,
// hand-written lock and async-reset sequences, then random traffic against a reference model.
module tb_ahb_slave_arbiter;
  localparam int N = 2;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [N-1:0]      hreq;
  logic [N-1:0]      hlock;
  logic [N-1:0][1:0] htrans_in;
  logic [N-1:0][2:0] hburst_in;
  logic              hready;
  logic [N-1:0]      hgrant;
  logic [N-1:0]      data_sel;
  logic [0:0]        hmaster;
  logic              hmastlock;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_arbiter #(.MASTER_NUM(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hreq(hreq), .hlock(hlock),
    .htrans_in(htrans_in), .hburst_in(hburst_in), .hready(hready),
    .hgrant(hgrant), .data_sel(data_sel), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  // ---------------- reference model: owner index, beats left, lock flag ----------------
  int m_owner, m_last, m_dsel, m_left;
  bit m_lock, m_burst, m_incr;

  function automatic void model_reset();
    m_owner = -1; m_last = N - 1; m_dsel = -1; m_left = 0;
    m_lock = 0; m_burst = 0; m_incr = 0;
  endfunction

  function automatic void model_rearb();
    int c;
    int r;
    r = int'(hreq);
    m_owner = -1; m_lock = 0; m_burst = 0; m_incr = 0; m_left = 0;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (m_owner < 0 && ((r >> c) & 1) == 1) m_owner = c;
    end
    if (m_owner >= 0) m_last = m_owner;
  endfunction

  function automatic void model_start(input int lk, input int bu);
    if (lk == 1) m_lock = 1;
    else if (bu == 0) model_rearb();
    else if (bu == 1) begin m_burst = 1; m_incr = 1; end
    else begin
      m_burst = 1; m_incr = 0;
      m_left = (2 ** (bu / 2 + 1)) - 1;   // SEQ beats still to come
    end
  endfunction

  function automatic void model_step();
    int o, tr, bu, lk, nd;
    if (!hready) return;
    nd = m_owner;
    o  = m_owner;
    if (o < 0) model_rearb();
    else begin
      tr = (int'(htrans_in) >> (2 * o)) & 3;
      bu = (int'(hburst_in) >> (3 * o)) & 7;
      lk = (int'(hlock) >> o) & 1;
      if (m_lock) begin
        if (lk == 0) begin m_lock = 0; m_burst = 0; m_incr = 0; end
      end else if (m_burst && tr != 2) begin
        if (tr == 3) begin
          if (!m_incr) begin
            m_left--;
            if (m_left == 0) model_rearb();
          end
        end else if (tr == 0) model_rearb();
      end else if (tr == 2) model_start(lk, bu);
      else model_rearb();
    end
    m_dsel = nd;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] eg, input logic [1:0] ed,
                           input logic em, input logic el);
    check({tag, " hgrant"},    32'(hgrant),    32'(eg));
    check({tag, " data_sel"},  32'(data_sel),  32'(ed));
    check({tag, " hmaster"},   32'(hmaster),   32'(em));
    check({tag, " hmastlock"}, 32'(hmastlock), 32'(el));
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] t0,
                       input logic [1:0] t1, input logic [2:0] b0, input logic [2:0] b1,
                       input logic rdy);
    hreq = req; hlock = lock;
    htrans_in[0] = t0; htrans_in[1] = t1;
    hburst_in[0] = b0; hburst_in[1] = b1;
    hready = rdy;
  endtask

  // One clock: inputs already applied at the negedge; model follows the edge; sample at next negedge.
  task automatic step();
    @(posedge HCLK);
    if (HRESETn) model_step();
    @(negedge HCLK);
  endtask

  typedef struct {
    logic [1:0] req, lock, t0, t1;
    logic [2:0] b0, b1;
    logic       rdy;
    logic [1:0] eg, ed;
    logic       em, el;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] t0,
                     input logic [1:0] t1, input logic [2:0] b0, input logic [2:0] b1,
                     input logic rdy, input logic [1:0] eg, input logic [1:0] ed,
                     input logic em, input logic el);
    vec_t v;
    v.req = req; v.lock = lock; v.t0 = t0; v.t1 = t1; v.b0 = b0; v.b1 = b1; v.rdy = rdy;
    v.eg = eg; v.ed = ed; v.em = em; v.el = el;
    tbl.push_back(v);
  endtask

  function automatic logic [1:0] rand_trans();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b01;
    if (r <= 3) return 2'b10;
    return 2'b11;
  endfunction

  localparam logic [1:0] I = 2'b00, B = 2'b01, NS = 2'b10, S = 2'b11;

  initial begin
    // req lock t0 t1 b0 b1 rdy | hgrant data_sel hmaster hmastlock
    add(2'b11, 2'b00, I,  I,  3'd0, 3'd0, 1, 2'b01, 2'b00, 0, 0); // first arbitration: master 0
    add(2'b11, 2'b00, NS, I,  3'd3, 3'd0, 1, 2'b01, 2'b01, 0, 0); // INCR4 NONSEQ, data phase follows
    add(2'b11, 2'b00, S,  I,  3'd3, 3'd0, 1, 2'b01, 2'b01, 0, 0);
    add(2'b11, 2'b00, S,  I,  3'd3, 3'd0, 1, 2'b01, 2'b01, 0, 0);
    add(2'b11, 2'b00, S,  I,  3'd3, 3'd0, 1, 2'b10, 2'b01, 1, 0); // 3rd SEQ: hand over to master 1
    add(2'b01, 2'b00, I,  I,  3'd0, 3'd0, 1, 2'b01, 2'b10, 0, 0); // master 1 idle: back to 0
    add(2'b01, 2'b00, NS, I,  3'd1, 3'd0, 1, 2'b01, 2'b01, 0, 0); // INCR burst
    add(2'b01, 2'b00, S,  I,  3'd1, 3'd0, 1, 2'b01, 2'b01, 0, 0);
    add(2'b01, 2'b00, B,  I,  3'd1, 3'd0, 1, 2'b01, 2'b01, 0, 0); // BUSY holds
    add(2'b01, 2'b00, S,  I,  3'd1, 3'd0, 1, 2'b01, 2'b01, 0, 0);
    add(2'b01, 2'b00, I,  I,  3'd1, 3'd0, 1, 2'b01, 2'b01, 0, 0); // early end, sole requester keeps grant
    add(2'b00, 2'b00, I,  I,  3'd0, 3'd0, 1, 2'b00, 2'b01, 0, 0); // nobody requests
    add(2'b00, 2'b00, I,  I,  3'd0, 3'd0, 1, 2'b00, 2'b00, 0, 0); // IDLE
    add(2'b10, 2'b00, I,  I,  3'd0, 3'd0, 1, 2'b10, 2'b00, 1, 0);
    add(2'b11, 2'b00, I,  NS, 3'd0, 3'd0, 1, 2'b01, 2'b10, 0, 0); // SINGLE releases
    add(2'b11, 2'b00, NS, I,  3'd5, 3'd0, 1, 2'b01, 2'b01, 0, 0); // INCR8 beat 1
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 1, 2'b01, 2'b01, 0, 0); // beat 2
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 1, 2'b01, 2'b01, 0, 0); // beat 3
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 0, 2'b01, 2'b01, 0, 0); // 3 wait states
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 0, 2'b01, 2'b01, 0, 0);
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 0, 2'b01, 2'b01, 0, 0);
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 1, 2'b01, 2'b01, 0, 0); // beat 4
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 1, 2'b01, 2'b01, 0, 0); // beat 5
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 1, 2'b01, 2'b01, 0, 0); // beat 6
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 1, 2'b01, 2'b01, 0, 0); // beat 7
    add(2'b11, 2'b00, S,  I,  3'd5, 3'd0, 1, 2'b10, 2'b01, 1, 0); // beat 8: rearbitrate
    add(2'b11, 2'b00, I,  I,  3'd0, 3'd0, 0, 2'b10, 2'b01, 1, 0); // stall: data_sel must not advance
    add(2'b11, 2'b00, I,  I,  3'd0, 3'd0, 1, 2'b01, 2'b10, 0, 0);

    model_reset();
    HRESETn = 1'b0;
    drive(2'b00, 2'b00, I, I, 3'd0, 3'd0, 0);
    #12;
    check_all("reset", 2'b00, 2'b00, 0, 0);

    // Release with hready low: no arbitration until an accepted edge.
    @(negedge HCLK);
    drive(2'b11, 2'b00, I, I, 3'd0, 3'd0, 0);
    HRESETn = 1'b1;
    step();
    check_all("post_reset_stall", 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].t0, tbl[i].t1, tbl[i].b0, tbl[i].b1, tbl[i].rdy);
      step();
      check_all($sformatf("row%0d", i), tbl[i].eg, tbl[i].ed, tbl[i].em, tbl[i].el);
    end

    // Locked sequence from master 1 while master 0 keeps requesting.
    drive(2'b10, 2'b00, I, I,  3'd0, 3'd0, 1); step(); check_all("lk_grant",  2'b10, 2'b01, 1, 0);
    drive(2'b11, 2'b10, I, NS, 3'd0, 3'd0, 1); step(); check_all("lk_enter",  2'b10, 2'b10, 1, 1);
    drive(2'b11, 2'b10, I, S,  3'd0, 3'd0, 1); step(); check_all("lk_hold1",  2'b10, 2'b10, 1, 1);
    drive(2'b01, 2'b10, I, I,  3'd0, 3'd0, 1); step(); check_all("lk_hold2",  2'b10, 2'b10, 1, 1);
    drive(2'b11, 2'b10, I, B,  3'd0, 3'd0, 1); step(); check_all("lk_hold3",  2'b10, 2'b10, 1, 1);
    drive(2'b11, 2'b10, I, S,  3'd0, 3'd0, 0); step(); check_all("lk_hold4",  2'b10, 2'b10, 1, 1);
    drive(2'b11, 2'b00, I, S,  3'd0, 3'd0, 1); step(); check_all("lk_exit",   2'b10, 2'b10, 1, 0);
    drive(2'b11, 2'b00, I, NS, 3'd0, 3'd0, 1); step(); check_all("lk_rearb",  2'b01, 2'b10, 0, 0);

    // WRAP16 interrupted by an asynchronous reset between clock edges.
    drive(2'b11, 2'b00, NS, I, 3'd6, 3'd0, 1); step(); check_all("wr_start", 2'b01, 2'b01, 0, 0);
    drive(2'b11, 2'b00, S,  I, 3'd6, 3'd0, 1); step(); check_all("wr_seq1",  2'b01, 2'b01, 0, 0);
    drive(2'b11, 2'b00, S,  I, 3'd6, 3'd0, 1); step(); check_all("wr_seq2",  2'b01, 2'b01, 0, 0);
    #2 HRESETn = 1'b0;
    #1 check_all("wr_async_rst", 2'b00, 2'b00, 0, 0);
    model_reset();
    @(negedge HCLK);
    drive(2'b11, 2'b00, I, I, 3'd0, 3'd0, 1);
    HRESETn = 1'b1;
    step(); check_all("wr_after_rst", 2'b01, 2'b00, 0, 0);

    // Reset during a locked sequence clears hmastlock without a clock.
    drive(2'b11, 2'b01, NS, I, 3'd0, 3'd0, 1); step(); check_all("rl_lock", 2'b01, 2'b01, 0, 1);
    #2 HRESETn = 1'b0;
    #1 check_all("rl_async_rst", 2'b00, 2'b00, 0, 0);
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Random traffic against the reference model, with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      hreq = N'($urandom);
      for (int m = 0; m < N; m++) begin
        hlock[m]     = ($urandom_range(0, 5) == 0);
        htrans_in[m] = rand_trans();
        hburst_in[m] = 3'($urandom);
      end
      hready = ($urandom_range(0, 3) != 0);
      step();
      check($sformatf("rnd%0d hgrant", i),    32'(hgrant),    (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
      check($sformatf("rnd%0d data_sel", i),  32'(data_sel),  (m_dsel < 0) ? 32'd0 : 32'(1 << m_dsel));
      check($sformatf("rnd%0d hmaster", i),   32'(hmaster),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
      check($sformatf("rnd%0d hmastlock", i), 32'(hmastlock), 32'(m_lock));
      if (i == 1500) begin
        #2 HRESETn = 1'b0;
        #1 check_all("rnd_async_rst", 2'b00, 2'b00, 0, 0);
        model_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_slave_arbiter.md
AHB_SLAVE_ARBITER -- requirements
Module: ahb_slave_arbiter

Interface
REQ-001 Parameter MASTER_NUM, default 2, number of masters sharing one slave port; legal range 2..16.
REQ-002 Derived width IDX_W = max(1, ceil(log2(MASTER_NUM))).
REQ-003 HCLK  in  1  single clock; all state updates on its rising edge.
REQ-004 HRESETn  in  1  reset; asynchronous and active-low.
REQ-005 hreq  in  MASTER_NUM  per-master request for this slave.
REQ-006 hlock  in  MASTER_NUM  per-master locked-transfer request.
REQ-007 htrans_in  in  MASTER_NUM x 2  per-master HTRANS: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 hburst_in  in  MASTER_NUM x 3  per-master HBURST: SINGLE=000, INCR=001, WRAP4/INCR4=010/011, WRAP8/INCR8=100/101, WRAP16/INCR16=110/111.
REQ-009 hready  in  1  slave HREADY; a transfer phase completes only when it is 1.
REQ-010 hgrant  out  MASTER_NUM  one-hot address-phase select, or all zero; drives the master-side payload mux sel.
REQ-011 data_sel  out  MASTER_NUM  one-hot data-phase select, or all zero; drives the response mux.
REQ-012 hmaster  out  IDX_W  binary index of hgrant, 0 when hgrant is zero.
REQ-013 hmastlock  out  1  high while the owner holds a locked sequence.

Function
REQ-014 Outputs hgrant, data_sel, hmaster and hmastlock SHALL be registered.
REQ-015 Owner g = index of hgrant; g_trans, g_burst and g_lock are the owner's htrans_in, hburst_in and hlock.
REQ-016 When hready=0, state, hgrant, data_sel, beat counter, RR pointer and hmastlock SHALL hold.
REQ-017 On each edge with hready=1, data_sel SHALL load the pre-edge hgrant, giving a 1-cycle address-to-data lag.
REQ-018 FSM states: IDLE, OWNED, BURST, LOCK.
REQ-019 Rearbitrate = pick the first i with hreq[i]=1, searching from last_owner+1 upward with wraparound.
REQ-020 The previous owner is checked last, so it retains the grant only when it is the sole requester.
REQ-021 A rearbitration with no requester SHALL set hgrant=0 and go to IDLE.
REQ-022 A rearbitration with a winner SHALL go to OWNED and set last_owner=winner.
REQ-023 IDLE: hgrant=0; on hready=1, rearbitrate.
REQ-024 OWNED, hready=1, g_trans=NONSEQ, g_lock=1: go to LOCK, set hmastlock=1, keep grant.
REQ-025 OWNED, hready=1, g_trans=NONSEQ, unlocked SINGLE: rearbitrate.
REQ-026 OWNED, hready=1, g_trans=NONSEQ, fixed burst of N beats: go to BURST, load beat counter with N-1 (3, 7 or 15).
REQ-027 OWNED, hready=1, g_trans=NONSEQ, INCR: go to BURST with the undefined-length flag set.
REQ-028 OWNED, hready=1, g_trans=IDLE, BUSY or SEQ: rearbitrate.
REQ-029 BURST, hready=1, g_trans=SEQ, fixed burst: decrement the counter; when the counter is 1 at this edge, rearbitrate.
REQ-030 BURST, hready=1, g_trans=SEQ, INCR: hold the grant.
REQ-031 BURST, hready=1, g_trans=BUSY: hold grant and counter.
REQ-032 BURST, hready=1, g_trans=IDLE: early termination; rearbitrate.
REQ-033 BURST, hready=1, g_trans=NONSEQ: treat as a new transfer using the OWNED rules.
REQ-034 LOCK: no rearbitration while g_lock=1, regardless of other hreq.
REQ-035 LOCK, hready=1, g_lock=0: clear hmastlock, go to OWNED with the same owner.
REQ-036 hgrant SHALL never have more than one bit set.
REQ-037 Owner hreq dropping mid-BURST or mid-LOCK SHALL NOT release the grant; only the htrans/hlock rules above do.
REQ-038 The beat counter is 4 bits and SHALL NOT wrap below 0.

Reset
REQ-039 While HRESETn=0: state=IDLE, hgrant=0, data_sel=0, hmaster=0, hmastlock=0, counter=0, last_owner=MASTER_NUM-1, so master 0 wins first.
REQ-040 Reset asserted mid-burst or mid-lock SHALL force the reset values immediately, without waiting for HCLK.
REQ-041 The first rearbitration SHALL occur on the first HCLK edge after HRESETn deasserts with hready=1.

Verification
REQ-042 Reset release, hreq=11, hready=1 -> edge 1: hgrant=01, hmaster=0; edge 2: data_sel=01.
REQ-043 Master 0 NONSEQ INCR4 then 3 SEQ, hreq=11 throughout -> hgrant=01 for 4 address beats, then 10 on the edge accepting the 3rd SEQ.
REQ-044 hready=0 for 3 cycles mid-INCR8 -> hgrant, data_sel and counter frozen; burst completes after 8 accepted beats total.
REQ-045 Master 1 locked NONSEQ with hlock[1]=1 for 5 cycles, hreq[0]=1 -> hgrant=10, hmastlock=1 throughout; hlock low at hready=1 -> OWNED, next transfer rearbitrates to 01.
REQ-046 INCR burst from master 0, htrans=IDLE after 2 SEQ, hreq=01 -> rearbitrates; hgrant stays 01 as sole requester; hreq=00 -> IDLE, hgrant=00.
REQ-047 HRESETn pulsed low mid-WRAP16 -> all outputs 0 asynchronously; after release, master 0 wins first.
